// File: rtl/byte_packer.sv
// Packs Ratio narrow elements into one wide word and writes it to a downstream FIFO.
// Optional partial-word flush is compiled in with `define BYTE_PACKER_FLUSH_EN.
module byte_packer #(
  parameter int InputWidth  = 8,
  parameter int OutputWidth = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [InputWidth-1:0]  data_i,
  output logic                   ready_o,
  input  logic                   flush_i,
  input  logic                   full_i,
  output logic                   write_en_o,
  output logic [OutputWidth-1:0] data_o
);

  localparam int Ratio = OutputWidth / InputWidth;
  localparam int LaneW = (Ratio > 2) ? $clog2(Ratio) : 1;
  localparam logic [LaneW-1:0] LastLane = LaneW'(Ratio - 1);

  generate
    if (Ratio < 2 || Ratio * InputWidth != OutputWidth) begin : g_bad_ratio
      $error("byte_packer: OutputWidth must be an integer multiple >= 2 of InputWidth");
    end
  endgenerate

  typedef enum logic {FILL, PEND} state_t;

  state_t                 state, state_nx;
  logic [LaneW-1:0]       lane, lane_nx;
  logic [OutputWidth-1:0] acc, acc_nx;
  logic [OutputWidth-1:0] held, held_nx;
  logic [OutputWidth-1:0] data_q, data_nx;
  logic [OutputWidth-1:0] word;
  logic                   wr_q, wr_nx;
  logic                   accept;
  logic                   last;
  logic                   flush_emit;

  assign ready_o    = (state == FILL);
  assign accept     = valid_i && ready_o;
  assign last       = accept && (lane == LastLane);
  assign write_en_o = wr_q;
  assign data_o     = data_q;

`ifdef BYTE_PACKER_FLUSH_EN
  // A flush that lands on the last lane is already a full word.
  assign flush_emit = flush_i && ready_o && !last
                      && ((lane != '0) || accept);
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign flush_emit   = 1'b0;
`endif

  always_comb begin
    word = acc;
    if (accept) begin
      word[int'(lane)*InputWidth +: InputWidth] = data_i;
    end
  end

  always_comb begin
    state_nx = state;
    lane_nx  = lane;
    acc_nx   = acc;
    held_nx  = held;
    data_nx  = data_q;
    wr_nx    = 1'b0;
    unique case (state)
      FILL: begin
        if (last || flush_emit) begin
          // Accumulator restarts from zero so unfilled lanes read as 0.
          lane_nx = '0;
          acc_nx  = '0;
          if (full_i) begin
            held_nx  = word;
            state_nx = PEND;
          end else begin
            wr_nx   = 1'b1;
            data_nx = word;
          end
        end else if (accept) begin
          lane_nx = lane + LaneW'(1);
          acc_nx  = word;
        end
      end
      PEND: begin
        if (!full_i) begin
          wr_nx    = 1'b1;
          data_nx  = held;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lane   <= '0;
      acc    <= '0;
      held   <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
    end else begin
      lane   <= lane_nx;
      acc    <= acc_nx;
      held   <= held_nx;
      data_q <= data_nx;
      wr_q   <= wr_nx;
    end
  end

endmodule
